// File: rtl/ddr5_phy_write_pkg.sv
// Shared types and constants for the DDR5 PHY write-path control FSM.
package ddr5_phy_write_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PREAMBLE   = 3'd1,
        WRDATA     = 3'd2,
        CRC        = 3'd3,
        INTERAMBLE = 3'd4,
        POSTAMBLE  = 3'd5
    } write_state_e;

    localparam logic [1:0] BL8             = 2'b01;
    localparam int         TIMEOUT_CYC_DEF = 15;

endpackage

// File: rtl/ddr5_phy_write_watchdog.sv
// Stall watchdog: per-state cycle counter that saturates at the limit,
// plus a sticky error flag raised when the limit is reached.
module ddr5_phy_write_watchdog #(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic state_change_i,
    input  logic in_idle_i,
    output logic expire_o,
    output logic err_o
);

    localparam logic [3:0] LIMIT = 4'(TIMEOUT_CYC);

    logic [3:0] cnt_q, cnt_d;
    logic       err_q, err_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_change_i || in_idle_i) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + 4'd1;
        end
        err_d = err_q | (cnt_d == LIMIT);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign expire_o = (cnt_q == LIMIT);
    assign err_o    = err_q;

endmodule

// File: rtl/ddr5_phy_write_fsm.sv
// DDR5 PHY write-path sequencer: preamble, data, optional CRC, then
// interamble/postamble; counts completed bursts and aborts stalled states.
//   state      | meaning
//   IDLE       | no write in progress
//   PREAMBLE   | DQS preamble (also reused for POSTAMBLE qualifier)
//   WRDATA     | data beats on DQ
//   CRC        | CRC beats after data
//   INTERAMBLE | short gap between back-to-back bursts
//   POSTAMBLE  | DQS postamble before going idle
module ddr5_phy_write_fsm
    import ddr5_phy_write_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       wr_en_i,
    input  logic [1:0] burstlength_i,
    input  logic       crc_generate_i,
    input  logic       interamble_i,
    input  logic       preamble_done_i,
    input  logic       wrdata_done_i,
    input  logic       wrmask_done_i,
    input  logic       data_burst_done_i,
    input  logic       wrdata_crc_done_i,
    input  logic       interamble_done_i,
    input  logic       postamble_done_i,
    output logic [2:0] state_o,
    output logic       preamble_state_o,
    output logic       data_state_o,
    output logic       crc_state_o,
    output logic       interamble_valid_o,
    output logic [7:0] burst_cnt_o,
    output logic       timeout_err_o
);

    write_state_e state_q, state_d, exit_state;
    logic [7:0]   burst_cnt_q, burst_cnt_d;
    logic         data_end, transition, abort, expire;

    assign data_end = (state_q == WRDATA) &&
                      (wrdata_done_i ||
                       ((burstlength_i == BL8) && data_burst_done_i) ||
                       (!crc_generate_i && wrmask_done_i));

    assign exit_state = wr_en_i      ? WRDATA :
                        interamble_i ? INTERAMBLE : POSTAMBLE;

    // A seamless WRDATA->WRDATA re-entry counts as a transition so the
    // watchdog restarts for each burst.
    always_comb begin
        state_d    = state_q;
        transition = 1'b0;
        abort      = 1'b0;
        unique case (state_q)
            IDLE:       if (wr_en_i)           begin state_d = PREAMBLE; transition = 1'b1; end
            PREAMBLE:   if (preamble_done_i)   begin state_d = WRDATA;   transition = 1'b1; end
            WRDATA:     if (data_end) begin
                            state_d    = crc_generate_i ? CRC : exit_state;
                            transition = 1'b1;
                        end
            CRC:        if (wrdata_crc_done_i) begin state_d = exit_state; transition = 1'b1; end
            INTERAMBLE: if (interamble_done_i) begin state_d = WRDATA;   transition = 1'b1; end
            POSTAMBLE:  if (postamble_done_i) begin
                            state_d    = wr_en_i ? PREAMBLE : IDLE;
                            transition = 1'b1;
                        end
            default:    begin state_d = IDLE; transition = 1'b1; end
        endcase
        if (!transition && expire) begin
            state_d = IDLE;
            abort   = 1'b1;
        end
        burst_cnt_d = burst_cnt_q + {7'd0, data_end};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    ddr5_phy_write_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .state_change_i (transition || abort),
        .in_idle_i      (state_q == IDLE),
        .expire_o       (expire),
        .err_o          (timeout_err_o)
    );

    always_comb begin
        state_o            = state_q;
        preamble_state_o   = (state_q == PREAMBLE) || (state_q == POSTAMBLE);
        data_state_o       = (state_q == WRDATA) || (state_q == CRC);
        crc_state_o        = (state_q == CRC);
        interamble_valid_o = (state_q == INTERAMBLE);
    end

    assign burst_cnt_o = burst_cnt_q;

endmodule

// File: tb/tb_ddr5_phy_write_fsm.sv
// Directed bench for the DDR5 PHY write FSM with hand-computed expectations.
module tb_ddr5_phy_write_fsm;
    import ddr5_phy_write_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       wr_en_i, crc_generate_i, interamble_i;
    logic [1:0] burstlength_i;
    logic       preamble_done_i, wrdata_done_i, wrmask_done_i, data_burst_done_i;
    logic       wrdata_crc_done_i, interamble_done_i, postamble_done_i;
    logic [2:0] state_o;
    logic       preamble_state_o, data_state_o, crc_state_o, interamble_valid_o;
    logic [7:0] burst_cnt_o;
    logic       timeout_err_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    ddr5_phy_write_fsm #(.TIMEOUT_CYC(15)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .wr_en_i            (wr_en_i),
        .burstlength_i      (burstlength_i),
        .crc_generate_i     (crc_generate_i),
        .interamble_i       (interamble_i),
        .preamble_done_i    (preamble_done_i),
        .wrdata_done_i      (wrdata_done_i),
        .wrmask_done_i      (wrmask_done_i),
        .data_burst_done_i  (data_burst_done_i),
        .wrdata_crc_done_i  (wrdata_crc_done_i),
        .interamble_done_i  (interamble_done_i),
        .postamble_done_i   (postamble_done_i),
        .state_o            (state_o),
        .preamble_state_o   (preamble_state_o),
        .data_state_o       (data_state_o),
        .crc_state_o        (crc_state_o),
        .interamble_valid_o (interamble_valid_o),
        .burst_cnt_o        (burst_cnt_o),
        .timeout_err_o      (timeout_err_o)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_flags();
        wr_en_i = 0; preamble_done_i = 0; wrdata_done_i = 0; wrmask_done_i = 0;
        data_burst_done_i = 0; wrdata_crc_done_i = 0; interamble_done_i = 0;
        postamble_done_i = 0;
    endtask

    // Drive wr_en for one cycle then preamble_done for one cycle: IDLE->PREAMBLE->WRDATA.
    task automatic enter_wrdata();
        wr_en_i = 1; tick(); wr_en_i = 0;
        preamble_done_i = 1; tick(); preamble_done_i = 0;
    endtask

    initial begin
        rst_i = 1; crc_generate_i = 0; interamble_i = 0; burstlength_i = 2'b00;
        clear_flags();
        repeat (3) @(posedge clk_i);
        #1 rst_i = 0;

        check("rst_state", state_o, IDLE);
        check("rst_burst", burst_cnt_o, 0);
        check("rst_err", timeout_err_o, 0);
        check("rst_quals", {preamble_state_o, data_state_o, crc_state_o, interamble_valid_o}, 0);

        // Single write, no CRC
        wr_en_i = 1; tick(); wr_en_i = 0;
        check("sw_pre", state_o, PREAMBLE);
        check("sw_pre_q", preamble_state_o, 1);
        repeat (3) tick();
        check("sw_pre_hold", state_o, PREAMBLE);
        preamble_done_i = 1; tick(); preamble_done_i = 0;
        check("sw_wr", state_o, WRDATA);
        check("sw_wr_q", {preamble_state_o, data_state_o}, 2'b01);
        postamble_done_i = 1; tick(); postamble_done_i = 0;
        check("sw_ignore_post", state_o, WRDATA);
        wrdata_done_i = 1; tick(); wrdata_done_i = 0;
        check("sw_post", state_o, POSTAMBLE);
        check("sw_burst", burst_cnt_o, 1);
        check("sw_post_q", {preamble_state_o, data_state_o}, 2'b10);
        postamble_done_i = 1; tick(); postamble_done_i = 0;
        check("sw_idle", state_o, IDLE);

        // CRC path; wrmask_done must not end data when CRC is generated
        crc_generate_i = 1;
        enter_wrdata();
        wrmask_done_i = 1; tick(); wrmask_done_i = 0;
        check("crc_mask_ign", state_o, WRDATA);
        wrdata_done_i = 1; tick(); wrdata_done_i = 0;
        check("crc_st1", state_o, CRC);
        check("crc_q1", {data_state_o, crc_state_o}, 2'b11);
        check("crc_burst", burst_cnt_o, 2);
        tick();
        check("crc_q2", {data_state_o, crc_state_o}, 2'b11);
        wrdata_crc_done_i = 1; tick(); wrdata_crc_done_i = 0;
        check("crc_post", state_o, POSTAMBLE);
        check("crc_q3", {data_state_o, crc_state_o}, 2'b00);
        check("crc_burst2", burst_cnt_o, 2);
        postamble_done_i = 1; tick(); postamble_done_i = 0;
        crc_generate_i = 0;

        // Back-to-back and interamble
        enter_wrdata();
        wr_en_i = 1; wrdata_done_i = 1; tick(); wr_en_i = 0; wrdata_done_i = 0;
        check("b2b_wr", state_o, WRDATA);
        check("b2b_burst", burst_cnt_o, 3);
        interamble_i = 1; wrdata_done_i = 1; tick(); wrdata_done_i = 0; interamble_i = 0;
        check("ia_state", state_o, INTERAMBLE);
        check("ia_valid", interamble_valid_o, 1);
        check("ia_burst", burst_cnt_o, 4);
        interamble_done_i = 1; tick(); interamble_done_i = 0;
        check("ia_wr", state_o, WRDATA);
        wrdata_done_i = 1; tick(); wrdata_done_i = 0;
        check("ia_post", state_o, POSTAMBLE);
        check("ia_burst2", burst_cnt_o, 5);
        wr_en_i = 1; postamble_done_i = 1; tick(); wr_en_i = 0; postamble_done_i = 0;
        check("post_to_pre", state_o, PREAMBLE);
        preamble_done_i = 1; tick(); preamble_done_i = 0;
        wrdata_done_i = 1; tick(); wrdata_done_i = 0;
        postamble_done_i = 1; tick(); postamble_done_i = 0;
        check("b2b_idle", state_o, IDLE);
        check("b2b_burst3", burst_cnt_o, 6);

        // BL8 exit via data_burst_done only
        burstlength_i = 2'b10;
        enter_wrdata();
        data_burst_done_i = 1; tick();
        check("bl8_not_bl8", state_o, WRDATA);
        burstlength_i = BL8; tick(); data_burst_done_i = 0;
        check("bl8_exit", state_o, POSTAMBLE);
        check("bl8_burst", burst_cnt_o, 7);
        postamble_done_i = 1; tick(); postamble_done_i = 0;
        burstlength_i = 2'b00;

        // Async reset mid-WRDATA
        enter_wrdata();
        check("ar_pre_state", state_o, WRDATA);
        check("ar_pre_burst", burst_cnt_o, 7);
        #2 rst_i = 1;
        #1;
        check("ar_state", state_o, IDLE);
        check("ar_burst", burst_cnt_o, 0);
        check("ar_quals", {preamble_state_o, data_state_o, crc_state_o, interamble_valid_o}, 0);
        #1 rst_i = 0;
        tick();

        // Timeout abort in PREAMBLE
        wr_en_i = 1; tick(); wr_en_i = 0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            check($sformatf("to_hold_%0d", i), state_o, PREAMBLE);
            if (i == 14) check("to_err_early", timeout_err_o, 0);
        end
        tick();
        check("to_idle", state_o, IDLE);
        check("to_err", timeout_err_o, 1);

        // Normal burst after abort (wrmask exit, no CRC); error stays sticky
        enter_wrdata();
        wrmask_done_i = 1; tick(); wrmask_done_i = 0;
        check("mask_post", state_o, POSTAMBLE);
        check("mask_burst", burst_cnt_o, 1);
        postamble_done_i = 1; tick(); postamble_done_i = 0;
        check("err_sticky", timeout_err_o, 1);

        // Done flag in the same cycle as expiry wins
        wr_en_i = 1; tick(); wr_en_i = 0;
        repeat (15) tick();
        preamble_done_i = 1; tick(); preamble_done_i = 0;
        check("race_wr", state_o, WRDATA);

        // Wrap: burst 2 on this exit, then 253 seamless bursts reach 255, one more wraps
        wr_en_i = 1; wrdata_done_i = 1;
        repeat (254) tick();
        check("wrap_255", burst_cnt_o, 255);
        check("wrap_state", state_o, WRDATA);
        tick();
        check("wrap_0", burst_cnt_o, 0);
        wr_en_i = 0; tick(); wrdata_done_i = 0;
        check("wrap_post", state_o, POSTAMBLE);
        check("wrap_1", burst_cnt_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ddr5_phy_write_fsm.md
# ddr5_phy_write_fsm

Control state machine for the DDR5 PHY write path. It consumes the done and qualifier flags from the write counters block and tracks one write burst sequence: preamble, data, optional CRC, then interamble or postamble. It drives the state-qualifier signals back to the counters and to the DQ/DQS serializers. It also counts completed bursts and flags a stalled sequence.

## Interface
Parameters:
- TIMEOUT_CYC, 15, maximum cycles in any non-IDLE state before abort; legal range 1..15.

Ports (one clock; reset is asynchronous and active-high):
- clk_i  in  1  PHY write clock
- rst_i  in  1  asynchronous, active-high reset
- wr_en_i  in  1  write enable from memory controller
- burstlength_i  in  2  burst length code; 2'b01 = BL8
- crc_generate_i  in  1  PHY generates and sends CRC
- interamble_i  in  1  gap is too short for postamble+preamble; use interamble
- preamble_done_i  in  1  preamble finished
- wrdata_done_i  in  1  data burst finished
- wrmask_done_i  in  1  data finished, mask case with no CRC
- data_burst_done_i  in  1  BL8 data finished
- wrdata_crc_done_i  in  1  CRC beats finished
- interamble_done_i  in  1  interamble finished
- postamble_done_i  in  1  postamble finished
- state_o  out  3  current state encoding
- preamble_state_o  out  1  high in PREAMBLE or POSTAMBLE
- data_state_o  out  1  high in WRDATA or CRC
- crc_state_o  out  1  high in CRC
- interamble_valid_o  out  1  high in INTERAMBLE
- burst_cnt_o  out  8  completed bursts, wraps 255→0
- timeout_err_o  out  1  sticky stall flag

## Operation
States: IDLE, PREAMBLE, WRDATA, CRC, INTERAMBLE, POSTAMBLE.
- IDLE: wr_en_i=1 → PREAMBLE.
- PREAMBLE: preamble_done_i → WRDATA.
- WRDATA: data ends when any of these is true:
  - wrdata_done_i
  - burstlength_i=2'b01 and data_burst_done_i
  - crc_generate_i=0 and wrmask_done_i
- At data end: crc_generate_i=1 → CRC; otherwise take the exit decision.
- CRC: wrdata_crc_done_i → exit decision.
- Exit decision, first match wins:
  - wr_en_i=1 → WRDATA (seamless back-to-back)
  - interamble_i=1 → INTERAMBLE
  - otherwise → POSTAMBLE
- INTERAMBLE: interamble_done_i → WRDATA.
- POSTAMBLE: postamble_done_i → PREAMBLE if wr_en_i=1, else IDLE.
- Done flags other than the one relevant to the current state are ignored.
- burst_cnt_o increments by 1 on every cycle a data end occurs (WRDATA exit, before CRC).
- Timeout counter (4 bits):
  - clears on every state change and while in IDLE;
  - otherwise increments by 1 per cycle;
  - reaching TIMEOUT_CYC forces IDLE next cycle and sets timeout_err_o;
  - holds at TIMEOUT_CYC until the state changes; never wraps.
- timeout_err_o clears only on reset.

## Timing
- Reset values: state IDLE, all outputs 0, burst_cnt_o 0, timeout counter 0. Reset asserted mid-sequence returns to IDLE immediately, asynchronously.
- state_o and the qualifier outputs are Moore decodes of the state register: no combinational path from any input to any output.
- Transition latency: a flag sampled high at edge N changes state_o after edge N.
- A done flag high in the same cycle as a timeout: the transition wins and the timeout counter clears.
- burst_cnt_o updates on the same edge as the WRDATA exit. 255 + 1 wraps to 0 with no flag.
- A wr_en_i pulse in PREAMBLE, INTERAMBLE or CRC has no effect beyond the exit decision.

## Structure
- Package ddr5_phy_write_pkg holds:
  - state enum write_state_e (3 bits): IDLE=0, PREAMBLE=1, WRDATA=2, CRC=3, INTERAMBLE=4, POSTAMBLE=5
  - BL8 code constant BL8=2'b01
  - TIMEOUT_CYC default
- One sub-module, ddr5_phy_write_watchdog: the 4-bit timeout counter plus the sticky error flag. Inputs are state_change and in_idle; output is expire.
- Next-state logic and output decode live in the top as separate always_comb blocks.

## Test plan
- Single write, no CRC: wr_en_i 1 cycle, preamble_done_i at cycle 5, wrdata_done_i at cycle 13, postamble_done_i at cycle 15 → states IDLE→PREAMBLE→WRDATA→POSTAMBLE→IDLE; burst_cnt_o=1; preamble_state_o high in PREAMBLE and POSTAMBLE only.
- CRC path: crc_generate_i=1, wrdata_done_i then wrdata_crc_done_i 2 cycles later → WRDATA→CRC→POSTAMBLE; crc_state_o high exactly 2 cycles; data_state_o high throughout WRDATA and CRC.
- Back-to-back and interamble:
  - wr_en_i=1 at data end → WRDATA re-entered with no PREAMBLE.
  - wr_en_i=0 with interamble_i=1 → INTERAMBLE; interamble_done_i → WRDATA; burst_cnt_o=2.
- BL8 mask: burstlength_i=2'b01, crc_generate_i=0, data_burst_done_i → exit WRDATA; an earlier wrdata_done_i=0 does not block the exit.
- Timeout: hold in PREAMBLE with preamble_done_i=0 for 15 cycles → IDLE on the 16th edge, timeout_err_o=1 and stays 1 through a later normal burst.
- Async reset asserted mid-WRDATA with burst_cnt_o=7 → all outputs 0 before the next clock edge; a 255→0 wrap of burst_cnt_o is checked by running 256 bursts.
